// File: rtl/prom_arb_pkg.sv
// Shared widths, tag encoding and read-mode constant for the pROM arbiter.
package prom_arb_pkg;

   localparam int PROM_ADDR_W     = 13;
   localparam int PROM_DATA_W     = 16;
   localparam int PROM_LAT_BYPASS = 1;

   // Identifies which requester issued an in-flight read.
   typedef enum logic {
      TAG_FETCH = 1'b0,
      TAG_DATA  = 1'b1
   } prom_tag_t;

endpackage

// File: rtl/prom_resp_pipe.sv
// DEPTH-deep {valid, tag} shift register that tracks reads in flight through
// the pROM so each returned word can be steered to the port that issued it.
module prom_resp_pipe
   import prom_arb_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic      clk,
   input  logic      clear,
   input  logic      in_valid,
   input  prom_tag_t in_tag,
   output logic      out_valid,
   output prom_tag_t out_tag,
   output logic      head_valid
);

   logic [DEPTH-1:0] valid_q;
   prom_tag_t        tag_q [DEPTH];

   // Valid bits shift toward the tail; a clear drops every read in flight.
   always_ff @(posedge clk) begin
      if (clear) begin
         valid_q <= '0;
      end else begin
         valid_q[0] <= in_valid;
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
         end
      end
   end

   // Tags only matter alongside a set valid bit, so they shift without reset.
   always_ff @(posedge clk) begin
      tag_q[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) begin
         tag_q[i] <= tag_q[i-1];
      end
   end

   assign out_valid  = valid_q[DEPTH-1];
   assign out_tag    = tag_q[DEPTH-1];
   assign head_valid = valid_q[0];

endmodule

// File: rtl/prom_arbiter.sv
// Two-port read arbiter in front of the single-port program pROM. Fetch has
// priority; a starvation counter forces a data grant after STARVE_MAX
// consecutive fetch grants while data is waiting.
//
// Handshake: a request is a level held by the requester; x_gnt is
// combinational and a transfer happens on a rising edge where x_req & x_gnt.
// Responses come back as a one-cycle x_rvalid pulse exactly ROM_LAT cycles
// after the grant edge, in grant order, with no backpressure.
module prom_arbiter
   import prom_arb_pkg::*;
#(
   parameter int ADDR_W     = PROM_ADDR_W,
   parameter int DATA_W     = PROM_DATA_W,
   parameter int ROM_LAT    = PROM_LAT_BYPASS,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_gnt,
   output logic              fetch_rvalid,
   output logic [DATA_W-1:0] fetch_rdata,
   input  logic              data_req,
   input  logic [ADDR_W-1:0] data_addr,
   output logic              data_gnt,
   output logic              data_rvalid,
   output logic [DATA_W-1:0] data_rdata,
   output logic              rom_ce,
   output logic              rom_oce,
   output logic              rom_reset,
   output logic [ADDR_W-1:0] rom_ad,
   input  logic [DATA_W-1:0] rom_dout
);

   if (ROM_LAT != 1 && ROM_LAT != 2) begin : g_bad_lat
      $error("prom_arbiter: ROM_LAT must be 1 (bypass) or 2 (pipeline)");
   end
   if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
      $error("prom_arbiter: STARVE_MAX must be in 1..15");
   end

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0]        starve_cnt;
   logic              data_win;
   logic [ADDR_W-1:0] last_ad;
   logic              pipe_valid;
   prom_tag_t         pipe_tag;
   prom_tag_t         issue_tag;
   logic              head_valid;

   // Grant decision: fetch by default, data when fetch is idle or starved.
   always_comb begin
      data_win  = data_req & (~fetch_req | (starve_cnt == STARVE_LIM));
      data_gnt  = ~reset & data_win;
      fetch_gnt = ~reset & fetch_req & ~data_win;
   end

   // Issue path: winning address, or the last issued address when idle.
   always_comb begin
      rom_ad    = last_ad;
      issue_tag = TAG_FETCH;
      if (fetch_gnt) begin
         rom_ad = fetch_addr;
      end else if (data_gnt) begin
         rom_ad    = data_addr;
         issue_tag = TAG_DATA;
      end
   end

   assign rom_ce    = fetch_gnt | data_gnt;
   assign rom_reset = reset;

   // Remember the issued address so rom_ad holds steady between grants.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_ad <= '0;
      end else if (rom_ce) begin
         last_ad <= rom_ad;
      end
   end

   // Count fetch grants that overtook a waiting data request.
   always_ff @(posedge clk) begin
      if (reset || data_gnt || !data_req) begin
         starve_cnt <= '0;
      end else if (fetch_gnt && starve_cnt != STARVE_LIM) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   prom_resp_pipe #(
      .DEPTH(ROM_LAT)
   ) u_resp_pipe (
      .clk       (clk),
      .clear     (reset),
      .in_valid  (rom_ce),
      .in_tag    (issue_tag),
      .out_valid (pipe_valid),
      .out_tag   (pipe_tag),
      .head_valid(head_valid)
   );

   // In pipeline mode the output register loads only when a read is in stage 1.
   assign rom_oce = (ROM_LAT == PROM_LAT_BYPASS) ? 1'b1 : head_valid;

   assign fetch_rvalid = pipe_valid & (pipe_tag == TAG_FETCH);
   assign data_rvalid  = pipe_valid & (pipe_tag == TAG_DATA);
   assign fetch_rdata  = rom_dout;
   assign data_rdata   = rom_dout;

endmodule
